// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared CPU widths, NOP encoding and fetch-stage types
package if_stage_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam logic [WORD_DATA_W-1:0] ISA_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } if_state_t;

    // Action applied to the IF output register in a given cycle
    typedef enum logic [1:0] {
        OUT_HOLD   = 2'd0,
        OUT_FETCH  = 2'd1,
        OUT_BUBBLE = 2'd2,
        OUT_BUF    = 2'd3
    } out_op_t;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [WORD_DATA_W-1:0] data;
    } fetch_word_t;

endpackage

// File: rtl/if_reg.sv
// rtl/if_reg.sv - IF output register plus one-entry skid buffer for stalled fetches
module if_reg
    import if_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  out_op_t                op,
    input  logic                   buf_wr,
    input  logic                   buf_clr,
    input  fetch_word_t            fetch,
    output logic [WORD_ADDR_W-1:0] if_pc,
    output logic [WORD_DATA_W-1:0] if_insn,
    output logic                   if_en
);

    fetch_word_t buf_q;
    logic        buf_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_pc   <= '0;
            if_insn <= ISA_NOP;
            if_en   <= 1'b0;
        end else begin
            case (op)
                OUT_FETCH: begin
                    if_pc   <= fetch.addr;
                    if_insn <= fetch.data;
                    if_en   <= 1'b1;
                end
                OUT_BUBBLE: begin
                    if_insn <= ISA_NOP;
                    if_en   <= 1'b0;
                end
                OUT_BUF: begin
                    if_pc   <= buf_q.addr;
                    if_insn <= buf_valid ? buf_q.data : ISA_NOP;
                    if_en   <= buf_valid;
                end
                default: ;
            endcase
        end
    end

    // The buffer is consumed by OUT_BUF and dropped on any redirect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q     <= '0;
            buf_valid <= 1'b0;
        end else if (buf_clr || op == OUT_BUF) begin
            buf_valid <= 1'b0;
        end else if (buf_wr) begin
            buf_q     <= fetch;
            buf_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: bus request FSM, PC tracking and redirects
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [WORD_ADDR_W-1:0] ResetVector = 30'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [WORD_ADDR_W-1:0] new_pc,
    input  logic                   br_taken,
    input  logic [WORD_ADDR_W-1:0] br_addr,
    output logic                   bus_req,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    input  logic [WORD_DATA_W-1:0] bus_rd_data,
    input  logic                   bus_rdy,
    output logic [WORD_ADDR_W-1:0] if_pc,
    output logic [WORD_DATA_W-1:0] if_insn,
    output logic                   if_en,
    output logic                   busy
);

    if_state_t              state_q, state_d;
    logic [WORD_ADDR_W-1:0] pc_q, pc_d;
    logic [WORD_ADDR_W-1:0] req_addr_q, req_addr_d;
    out_op_t                out_op;
    logic                   buf_wr;
    logic                   buf_clr;
    fetch_word_t            fetch_word;

    logic redirect;
    assign redirect = flush || (!stall && br_taken);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (redirect)
                    state_d = bus_rdy ? REQ : DROP;
                else if (stall && bus_rdy)
                    state_d = HOLD;
            end
            HOLD: begin
                if (flush || !stall)
                    state_d = REQ;
            end
            DROP: begin
                // A flush here leaves the old request still owed by the bus
                if (!flush && bus_rdy)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_req    = 1'b0;
        bus_addr   = pc_q;
        busy       = 1'b0;
        out_op     = OUT_HOLD;
        buf_wr     = 1'b0;
        buf_clr    = 1'b0;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        case (state_q)
            REQ: begin
                bus_req    = 1'b1;
                bus_addr   = pc_q;
                busy       = !bus_rdy;
                req_addr_d = pc_q;
                if (flush) begin
                    pc_d    = new_pc;
                    out_op  = OUT_BUBBLE;
                    buf_clr = 1'b1;
                end else if (stall) begin
                    if (bus_rdy) begin
                        buf_wr = 1'b1;
                        pc_d   = pc_q + 1'b1;
                    end
                end else if (br_taken) begin
                    pc_d    = br_addr;
                    out_op  = OUT_BUBBLE;
                    buf_clr = 1'b1;
                end else if (bus_rdy) begin
                    out_op = OUT_FETCH;
                    pc_d   = pc_q + 1'b1;
                end else begin
                    out_op = OUT_BUBBLE;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d    = new_pc;
                    out_op  = OUT_BUBBLE;
                    buf_clr = 1'b1;
                end else if (!stall && br_taken) begin
                    pc_d    = br_addr;
                    out_op  = OUT_BUBBLE;
                    buf_clr = 1'b1;
                end else if (!stall) begin
                    out_op = OUT_BUF;
                end
            end
            DROP: begin
                bus_req  = 1'b1;
                bus_addr = req_addr_q;
                busy     = 1'b1;
                if (flush) begin
                    pc_d    = new_pc;
                    out_op  = OUT_BUBBLE;
                    buf_clr = 1'b1;
                end else if (!stall && br_taken) begin
                    pc_d    = br_addr;
                    out_op  = OUT_BUBBLE;
                    buf_clr = 1'b1;
                end else if (!stall) begin
                    out_op = OUT_BUBBLE;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= ResetVector;
            req_addr_q <= ResetVector;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign fetch_word = '{addr: pc_q, data: bus_rd_data};

    if_reg u_if_reg (
        .clk     (clk),
        .rst     (rst),
        .op      (out_op),
        .buf_wr  (buf_wr),
        .buf_clr (buf_clr),
        .fetch   (fetch_word),
        .if_pc   (if_pc),
        .if_insn (if_insn),
        .if_en   (if_en)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage with an in-order scoreboard
module tb_if_stage;
    import if_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   stall = 1'b0;
    logic                   flush = 1'b0;
    logic [WORD_ADDR_W-1:0] new_pc = '0;
    logic                   br_taken = 1'b0;
    logic [WORD_ADDR_W-1:0] br_addr = '0;
    logic                   bus_req;
    logic [WORD_ADDR_W-1:0] bus_addr;
    logic [WORD_DATA_W-1:0] bus_rd_data;
    logic                   bus_rdy = 1'b0;
    logic [WORD_ADDR_W-1:0] if_pc;
    logic [WORD_DATA_W-1:0] if_insn;
    logic                   if_en;
    logic                   busy;

    int checks = 0;
    int errors = 0;
    fetch_word_t            sb[$];
    logic [WORD_ADDR_W-1:0] last_pc = '0;

    always #5 clk = ~clk;

    function automatic logic [WORD_DATA_W-1:0] mem(input logic [WORD_ADDR_W-1:0] a);
        return {2'b11, a} ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory responder
    assign bus_rd_data = bus_rdy ? mem(bus_addr) : 32'hDEAD_BEEF;

    if_stage #(.ResetVector(30'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .new_pc      (new_pc),
        .br_taken    (br_taken),
        .br_addr     (br_addr),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_rd_data (bus_rd_data),
        .bus_rdy     (bus_rdy),
        .if_pc       (if_pc),
        .if_insn     (if_insn),
        .if_en       (if_en),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit st, input bit fl, input bit br, input bit rdy,
                          input logic [WORD_ADDR_W-1:0] np, input logic [WORD_ADDR_W-1:0] ba);
        stall = st; flush = fl; br_taken = br; bus_rdy = rdy; new_pc = np; br_addr = ba;
    endtask

    task automatic chk_bus(input logic req, input logic [WORD_ADDR_W-1:0] addr, input logic bsy);
        #1;
        chk("bus_req", bus_req, req);
        if (req) chk("bus_addr", bus_addr, addr);
        chk("busy", busy, bsy);
    endtask

    task automatic tick(input bit new_word, input bit exp_en);
        fetch_word_t e;
        @(posedge clk);
        #1;
        chk("if_en", if_en, exp_en);
        if (new_word) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_empty: observed if_pc %0h expected a queued word", if_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("if_pc", if_pc, e.addr);
                chk("if_insn", if_insn, e.data);
                last_pc = e.addr;
            end
        end else if (exp_en) begin
            chk("if_pc_hold", if_pc, last_pc);
        end else begin
            chk("if_insn_nop", if_insn, ISA_NOP);
        end
    endtask

    task automatic fetch_step(input logic [WORD_ADDR_W-1:0] a);
        set_in(0, 0, 0, 1, '0, '0);
        chk_bus(1, a, 0);
        sb.push_back('{addr: a, data: mem(a)});
        tick(1, 1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_if_en", if_en, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_if_insn", if_insn, ISA_NOP);
        rst = 1'b0;

        // IDLE for one cycle, then streaming fetch from 0
        set_in(0, 0, 0, 1, '0, '0);
        chk_bus(0, '0, 0);
        tick(0, 0);
        for (int i = 0; i < 5; i++) fetch_step(30'(i));

        // Wait states at PC=5
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, '0, '0);
            chk_bus(1, 30'd5, 1);
            tick(0, 0);
        end
        for (int i = 5; i < 8; i++) fetch_step(30'(i));

        // Stall while the bus returns PC=8: word parks in the buffer
        set_in(1, 0, 0, 1, '0, '0);
        chk_bus(1, 30'd8, 0);
        tick(0, 1);
        chk_bus(0, '0, 0);
        tick(0, 1);
        set_in(0, 0, 0, 1, '0, '0);
        chk_bus(0, '0, 0);
        sb.push_back('{addr: 30'd8, data: mem(30'd8)});
        tick(1, 1);
        for (int i = 9; i < 12; i++) fetch_step(30'(i));

        // Branch to 40 while PC=12 is still outstanding
        set_in(0, 0, 1, 0, '0, 30'd40);
        chk_bus(1, 30'd12, 1);
        tick(0, 0);
        set_in(0, 0, 0, 0, '0, '0);
        for (int i = 0; i < 2; i++) begin
            chk_bus(1, 30'd12, 1);
            tick(0, 0);
        end
        set_in(0, 0, 0, 1, '0, '0);
        chk_bus(1, 30'd12, 1);
        tick(0, 0);
        fetch_step(30'd40);
        fetch_step(30'd41);

        // Flush beats stall and branch
        set_in(1, 1, 1, 1, 30'd100, 30'd55);
        chk_bus(1, 30'd42, 0);
        tick(0, 0);
        fetch_step(30'd100);

        // Flush while waiting, then flush again inside DROP
        set_in(0, 1, 0, 0, 30'd200, '0);
        chk_bus(1, 30'd101, 1);
        tick(0, 0);
        set_in(0, 1, 0, 0, 30'd300, '0);
        chk_bus(1, 30'd101, 1);
        tick(0, 0);
        set_in(0, 0, 0, 1, '0, '0);
        chk_bus(1, 30'd101, 1);
        tick(0, 0);
        fetch_step(30'd300);

        // Branch in HOLD discards the buffered word
        set_in(1, 0, 0, 1, '0, '0);
        chk_bus(1, 30'd301, 0);
        tick(0, 1);
        set_in(0, 0, 1, 1, '0, 30'd500);
        chk_bus(0, '0, 0);
        tick(0, 0);
        fetch_step(30'd500);

        // PC wrap-around
        set_in(0, 1, 0, 1, 30'h3FFF_FFFF, '0);
        tick(0, 0);
        fetch_step(30'h3FFF_FFFF);
        fetch_step(30'h0);

        // Reset in the middle of a pending request
        set_in(0, 0, 0, 0, '0, '0);
        chk_bus(1, 30'd1, 1);
        tick(0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_if_en", if_en, 0);
        bus_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_if_en_hold", if_en, 0);
        rst = 1'b0;
        chk_bus(0, '0, 0);
        tick(0, 0);
        fetch_step(30'd0);
        fetch_step(30'd1);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
